dmem_stage: RTL and testbench
=============================

Name: dmem_stage

Overview:
Multi-cycle data-memory block for the MIPS pipeline's Memory stage. It is fed directly by the datapath's Memory-stage outputs (ALU result address, store data, write enable, memtoreg). It returns the load word that the Write-back register captures. It models a memory with a fixed access latency and raises a stall to the hazard unit, which freezes the whole pipeline until the access completes.

Parameters:
ADDR_W, 8, word-index width; memory depth is 2^ADDR_W 32-bit words
WAIT_CYCLES, 2, access latency in cycles; legal range 1..15

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
addr_m  input  32  byte address (ALU result of the Memory stage)
wdata_m  input  32  store data
we_m  input  1  store request (memwrite of the Memory stage)
re_m  input  1  load request (memtoreg of the Memory stage)
readdata_m  output  32  load data to the Write-back register
stall_m  output  1  access in progress; hazard unit holds the pipeline
misalign_m  output  1  sticky flag: misaligned or conflicting request seen
busy_cnt  output  4  remaining wait cycles, for debug

Behaviour:
- One clock, synchronous active-high reset. Reset is sampled only on the rising edge of clk.
- Reset values: state=IDLE, readdata_m=0, stall_m=0, misalign_m=0, busy_cnt=0, all memory words=0.
- Word index is addr_m[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- Request: req = we_m | re_m. If both are set, the access is a store and misalign_m is set.
- Misaligned request (addr_m[1:0] != 0):
  - No memory access takes place and stall_m stays 0.
  - misalign_m is set and stays set until rst.
  - readdata_m is unchanged.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall_m = req & aligned. This is combinational, so the stall is high in the same cycle the request appears.
  - On an aligned request, load cnt = WAIT_CYCLES-1. If cnt is 0, go to DONE; otherwise go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - stall_m = 1.
  - If cnt == 1, go to DONE; otherwise decrement cnt.
  - The upstream pipeline holds addr_m, wdata_m, we_m and re_m stable while stall_m = 1. The block re-samples them on every cycle.
- Entering DONE (the edge that ends the last stall cycle):
  - A store writes mem[idx] <= wdata_m.
  - A load captures readdata_m <= mem[idx].
- DONE:
  - stall_m = 0, so the pipeline advances on this edge.
  - Next state is IDLE unconditionally.
  - readdata_m holds its captured value until the next load completes. Stores do not change readdata_m.
- Latency: a request first seen in cycle T produces stall_m=1 for exactly WAIT_CYCLES cycles (T .. T+WAIT_CYCLES-1). Cycle T+WAIT_CYCLES is DONE, with stall_m=0 and load data valid.
- Back-to-back: a new request presented in the cycle after DONE is accepted in IDLE. This gives WAIT_CYCLES+1 cycles per access.
- Load after store to the same address returns the stored value, because the store has committed before the load starts.
- busy_cnt shows cnt in BUSY and 0 in IDLE and DONE.
- Reset mid-access (in BUSY): the FSM returns to IDLE and the access is abandoned. A pending store is not committed.

Test Plan:
- Reset, then store 0xDEADBEEF to address 0x10 (WAIT_CYCLES=2):
  - stall_m is 1 in cycles T and T+1 and 0 in T+2.
  - A subsequent load from 0x10 gives readdata_m=0xDEADBEEF in its DONE cycle; stall_m pulses for exactly 2 cycles.
- Load from never-written address 0x40 after reset -> readdata_m=0x00000000. A store to 0x40 of 0x12345678 then leaves readdata_m at 0.
- Load from 0x13 (misaligned):
  - stall_m stays 0 and misalign_m rises and stays 1.
  - readdata_m is unchanged and memory is unchanged.
- Assert rst in the first BUSY cycle of a store of 0xAAAA5555 to 0x20 -> state returns to IDLE and stall_m=0. A later load from 0x20 returns 0.
- With ADDR_W=8, store 0x11 to 0x400 -> a load from 0x000 returns 0x11 (wrap-around).
- With WAIT_CYCLES=1, run back-to-back load, store and load to 0x8 -> each access stalls 1 cycle. The second load returns the stored value, with DONE at T+1 for each access.

Source files
------------

// File: rtl/dmem_stage.sv
// Multi-cycle data memory for the Memory stage: fixed-latency access with a
// pipeline stall, sticky misalignment flag and a debug wait counter.
module dmem_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        we_m,
  input  logic        re_m,
  output logic [31:0] readdata_m,
  output logic        stall_m,
  output logic        misalign_m,
  output logic [3:0]  busy_cnt
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_BUSY   = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       readdata_q;
  logic              misalign_q, misalign_d;
  logic [31:0]       mem_q [DEPTH];
  logic              req_s, aligned_s, commit_s, stall_s;
  logic [ADDR_W-1:0] idx_s;
  logic              unused_s;

  assign req_s     = we_m | re_m;
  assign aligned_s = (addr_m[1:0] == 2'b00);
  assign idx_s     = addr_m[ADDR_W+1:2];
  assign unused_s  = ^addr_m[31:ADDR_W+2];

  // Next-state, stall and commit decode; commit marks the edge entering DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    commit_s   = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && (!aligned_s || (we_m && re_m))) begin
          misalign_d = 1'b1;
        end else begin
          misalign_d = misalign_q;
        end
        if (req_s && aligned_s) begin
          stall_s = 1'b1;
          cnt_d   = CNT_INIT;
          if (CNT_INIT == 4'd0) begin
            state_d  = S_DONE;
            commit_s = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_s = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d  = S_DONE;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, flags and memory; reset abandons any in-flight store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'd0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      if (commit_s && we_m) begin
        mem_q[idx_s] <= wdata_m;
      end else if (commit_s) begin
        readdata_q <= mem_q[idx_s];
      end else begin
        readdata_q <= readdata_q;
      end
    end
  end

  assign readdata_m = readdata_q;
  assign misalign_m = misalign_q;
  assign stall_m    = stall_s;
  assign busy_cnt   = (state_q == S_BUSY) ? cnt_q : 4'd0;

endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench: two instances (WAIT_CYCLES 2 and 1) driven by directed and
// random accesses; a negedge monitor checks each completed access.
module tb_dmem_stage;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        we_s    [2];
  logic        re_s    [2];
  logic [31:0] rd_s    [2];
  logic        stall_s [2];
  logic        mis_s   [2];
  logic [3:0]  bc_s    [2];

  int wc [2] = '{2, 1};
  int n_pass = 0;
  int n_total = 0;
  int run [2] = '{0, 0};

  logic [31:0] mem_m [2][256];
  logic [31:0] rd_m  [2];
  logic        mis_m [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  dmem_stage #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .addr_m(addr_s[0]), .wdata_m(wdata_s[0]),
    .we_m(we_s[0]), .re_m(re_s[0]), .readdata_m(rd_s[0]), .stall_m(stall_s[0]),
    .misalign_m(mis_s[0]), .busy_cnt(bc_s[0]));

  dmem_stage #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .addr_m(addr_s[1]), .wdata_m(wdata_s[1]),
    .we_m(we_s[1]), .re_m(re_s[1]), .readdata_m(rd_s[1]), .stall_m(stall_s[1]),
    .misalign_m(mis_s[1]), .busy_cnt(bc_s[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 256; i++) mem_m[d][i] = 32'd0;
    rd_m[d]  = 32'd0;
    mis_m[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request on instance d; called right after a rising edge with the DUT idle.
  task automatic access(input int d, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   idx;
    we_s[d] = we; re_s[d] = re; addr_s[d] = a; wdata_s[d] = wd;
    if (a[1:0] != 2'b00) begin
      mis_m[d] = 1'b1;
      @(negedge clk);
      chk($sformatf("mis_stall%0d", d), {31'd0, stall_s[d]}, 32'd0);
      @(posedge clk); #1;
      we_s[d] = 1'b0; re_s[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("mis_flag%0d", d), {31'd0, mis_s[d]}, 32'd1);
      chk($sformatf("mis_rd%0d", d), rd_s[d], rd_m[d]);
      @(posedge clk); #1;
    end else begin
      idx = int'((a / 32'd4) % 32'd256);
      if (we && re) mis_m[d] = 1'b1;
      if (we) mem_m[d][idx] = wd;
      else    rd_m[d] = mem_m[d][idx];
      e.rd = rd_m[d];
      e.mis = mis_m[d];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      repeat (wc[d] + 1) @(posedge clk);
      #1;
      we_s[d] = 1'b0; re_s[d] = 1'b0;
    end
  endtask

  // Store interrupted by reset in its first BUSY cycle.
  task automatic rst_busy(input int d, input logic [31:0] a, input logic [31:0] wd);
    we_s[d] = 1'b1; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk); #1;
    rst_s[d] = 1'b1;
    @(posedge clk); #1;
    rst_s[d] = 1'b0; we_s[d] = 1'b0;
    model_reset(d);
    @(negedge clk);
    chk($sformatf("rstbusy_stall%0d", d), {31'd0, stall_s[d]}, 32'd0);
    chk($sformatf("rstbusy_cnt%0d", d), {28'd0, bc_s[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: counts stall cycles and checks each access when stall drops.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_s[d]) begin
        run[d] = 0;
      end else if (stall_s[d]) begin
        chk($sformatf("busy_cnt%0d", d), {28'd0, bc_s[d]},
            (run[d] == 0) ? 32'd0 : 32'(wc[d] - run[d]));
        run[d]++;
      end else if (run[d] != 0) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk($sformatf("sb_unexpected%0d", d), 32'd1, 32'd0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("stall_len%0d", d), 32'(run[d]), 32'(wc[d]));
          chk($sformatf("readdata%0d", d), rd_s[d], e.rd);
          chk($sformatf("misalign%0d", d), {31'd0, mis_s[d]}, {31'd0, e.mis});
          chk($sformatf("done_cnt%0d", d), {28'd0, bc_s[d]}, 32'd0);
        end
        run[d] = 0;
      end
    end
  end

  initial begin
    logic [31:0] r;
    int op;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
      we_s[d] = 1'b0; re_s[d] = 1'b0;
      model_reset(d);
    end
    idle(2);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rd%0d", d), rd_s[d], 32'd0);
      chk($sformatf("rst_stall%0d", d), {31'd0, stall_s[d]}, 32'd0);
      chk($sformatf("rst_mis%0d", d), {31'd0, mis_s[d]}, 32'd0);
      chk($sformatf("rst_cnt%0d", d), {28'd0, bc_s[d]}, 32'd0);
    end
    @(posedge clk); #1;

    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h10, 32'd0);
    access(0, 1'b0, 1'b1, 32'h40, 32'd0);
    access(0, 1'b1, 1'b0, 32'h40, 32'h12345678);
    idle(1);
    access(0, 1'b0, 1'b1, 32'h13, 32'd0);
    access(0, 1'b0, 1'b1, 32'h10, 32'd0);
    rst_busy(0, 32'h20, 32'hAAAA5555);
    access(0, 1'b0, 1'b1, 32'h20, 32'd0);
    access(0, 1'b1, 1'b0, 32'h400, 32'h11);
    access(0, 1'b0, 1'b1, 32'h000, 32'd0);
    access(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    access(0, 1'b0, 1'b1, 32'h30, 32'd0);

    access(1, 1'b0, 1'b1, 32'h8, 32'd0);
    access(1, 1'b1, 1'b0, 32'h8, 32'h5A5AA5A5);
    access(1, 1'b0, 1'b1, 32'h8, 32'd0);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 80; k++) begin
        r  = $urandom();
        op = int'($urandom_range(0, 11));
        if (op == 0)
          access(d, 1'b0, 1'b1, {r[31:10], 4'b0000, r[5:2], r[1], 1'b1}, 32'd0);
        else if (op == 1)
          access(d, 1'b1, 1'b1, {r[31:10], 4'b0000, r[5:2], 2'b00}, $urandom());
        else if (op == 2)
          rst_busy(d, {r[31:10], 4'b0000, r[5:2], 2'b00}, $urandom());
        else
          access(d, r[6], ~r[6], {r[31:10], 4'b0000, r[5:2], 2'b00}, $urandom());
        idle(int'($urandom_range(0, 2)));
      end
    end

    idle(6);
    chk("sb_left0", 32'(q0.size()), 32'd0);
    chk("sb_left1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
